lcd_ctrl: RTL and testbench
===========================

# lcd_ctrl

HD44780-style character LCD controller for the RV32I SoC, sitting directly downstream of the load/store unit's memory-mapped LCD register. It accepts one byte per write (command or data, selected by RS), drives the LCD bus with the required setup, enable-pulse and hold timing, and then holds off further writes for the controller's execution time. Software polls `o_busy` through the I/O read path instead of bit-banging enable timing.

## Interface
Parameters:
- `SETUP_CYC`, 2: cycles RS/data are stable before EN rises (≥1).
- `PULSE_CYC`, 12: EN high width in cycles (≥1).
- `HOLD_CYC`, 2: cycles RS/data are held after EN falls (≥1).
- `EXEC_CYC`, 2000: post-pulse wait for ordinary commands and data (≥1).
- `CLEAR_CYC`, 80000: post-pulse wait for clear/home commands (RS=0, data 0x01, 0x02 or 0x03).
- `POWERUP_CYC`, 800000: delay after reset before the init sequence; used only with `LCD_INIT_EN`.

Ports (single clock; reset is synchronous and active-high):
- `i_clk`: input, 1 bit. Clock.
- `i_reset`: input, 1 bit. Synchronous, active-high reset.
- `i_valid`: input, 1 bit. Write request strobe from the LSU LCD register decode.
- `i_rs`: input, 1 bit. Register select: 0 = command, 1 = data.
- `i_data`: input, 8 bits. Byte to send.
- `i_on`: input, 1 bit. Display power enable (bit 31 of the LCD word).
- `o_ready`: output, 1 bit. Can accept a write this cycle.
- `o_busy`: output, 1 bit. Equal to `~o_ready`; readable by software.
- `o_lcd_data`: output, 8 bits. LCD DB[7:0].
- `o_lcd_rs`: output, 1 bit. LCD RS.
- `o_lcd_rw`: output, 1 bit. LCD RW. Constant 0 (write-only).
- `o_lcd_en`: output, 1 bit. LCD E.
- `o_lcd_on`: output, 1 bit. Registered copy of `i_on`.

## Operation
- FSM states: `IDLE`, `SETUP`, `PULSE`, `HOLD`, `WAIT`, plus `PWRUP` and `INIT` when `LCD_INIT_EN` is defined.
- Acceptance:
  - A write is accepted on a clock edge where `i_valid & o_ready`.
  - `i_rs` and `i_data` are latched into `o_lcd_rs` and `o_lcd_data` on that edge.
  - `i_valid` while not ready is dropped, not queued. Software must poll `o_busy`.
- Sequence after acceptance:
  - `SETUP` for SETUP_CYC cycles with EN=0.
  - `PULSE` for PULSE_CYC cycles with EN=1.
  - `HOLD` for HOLD_CYC cycles with EN=0.
  - `WAIT` for EXEC_CYC or CLEAR_CYC cycles, then `IDLE`.
- Wait-length selection: CLEAR_CYC applies iff the latched RS=0 and the latched data ∈ {0x01, 0x02, 0x03}. All other writes use EXEC_CYC.
- `o_lcd_rs` and `o_lcd_data` stay constant from acceptance through `WAIT`. They retain their last value in `IDLE`.
- Timing counter:
  - One down-counter, 20 bits wide, shared by all states.
  - It is loaded with (N−1) on entry to each timed state; the state exits when the counter reaches 0.
  - The counter never wraps.
- `o_lcd_on` follows `i_on` with one cycle of delay in every state, independent of the FSM.
- Reset:
  - Values: `o_lcd_en`=0, `o_lcd_rs`=0, `o_lcd_data`=0x00, `o_lcd_on`=0, counter=0.
  - FSM goes to `IDLE`, or to `PWRUP` when `LCD_INIT_EN` is defined.
  - Reset mid-transfer aborts the transfer immediately: EN is low in the cycle after the reset edge and the transfer is not resumed.

## Timing
- `o_ready` is high only in `IDLE`. It is combinational from the state register.
- Latency, counting the acceptance edge as cycle 0:
  - EN rises at cycle SETUP_CYC+1.
  - EN falls at cycle SETUP_CYC+PULSE_CYC+1.
  - `o_ready` returns at cycle SETUP_CYC+PULSE_CYC+HOLD_CYC+WAIT+1.
- Back-to-back: `i_valid` held high is accepted on the first edge where `o_ready` is high. The minimum gap between acceptances equals the full latency.
- `o_lcd_en` is registered and glitch-free.

## Configuration
- `LCD_INIT_EN` defined:
  - After reset the FSM spends POWERUP_CYC cycles in `PWRUP`.
  - It then issues the ROM sequence 0x38, 0x0C, 0x06, 0x01 (RS=0) through the normal SETUP/PULSE/HOLD/WAIT path. The final 0x01 uses CLEAR_CYC.
  - `o_ready`=0 from reset until the sequence completes, and `i_valid` is ignored during that time.
- `LCD_INIT_EN` undefined:
  - No `PWRUP`/`INIT` states and no ROM.
  - `o_ready`=1 in the first cycle after reset deasserts.

## Structure
- Shared package `lcd_pkg`:
  - State enum `lcd_state_t`.
  - Command constants `LCD_CMD_CLEAR`=0x01, `LCD_CMD_HOME`=0x02, `LCD_CMD_FUNC8`=0x38, `LCD_CMD_DISPON`=0x0C, `LCD_CMD_ENTRY`=0x06.
  - Init ROM length constant = 4.
- Sub-module `lcd_timer`: a load/decrement down-counter with a `done` flag, instantiated once.

## Test plan
Bench parameters: SETUP=1, PULSE=3, HOLD=1, EXEC=5, CLEAR=20, POWERUP=10.

- Data write, init off: RS=1, data 0x41 accepted at cycle 0 → EN high during cycles 2–4; `o_lcd_data`=0x41 and RS=1 throughout; `o_ready` high again at cycle 11.
- Clear command: RS=0, data 0x01 → `o_ready` returns at cycle 26. Also send RS=1, data 0x01 → returns at cycle 11.
- Busy drop: a second `i_valid` with data 0x42 at cycle 5 → ignored; `o_lcd_data` stays 0x41 and only one EN pulse occurs.
- Reset mid-pulse: assert `i_reset` at cycle 3 → EN=0 and all LCD outputs zero the next cycle; `o_ready`=1 after reset releases (init off).
- Init on: release reset → `o_ready`=0; after 10 idle cycles, EN pulses carry 0x38, 0x0C, 0x06, 0x01 in order; `o_ready` rises only after the 0x01 clear wait.
- `i_on` toggle in any state → `o_lcd_on` follows one cycle later; the FSM is unaffected.

Source files
------------

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared definitions for the HD44780-style LCD controller.
//   lcd_state_t    - controller FSM states (PWRUP/INIT exist only with LCD_INIT_EN)
//   LCD_CMD_*      - HD44780 command bytes used by the controller
//   LCD_INIT_LEN   - number of bytes in the power-on init ROM
//   LCD_TMR_W      - width of the shared timing down-counter
//   cyc_load()     - converts a cycle count N into the counter load value N-1
//   is_clear_cmd() - true for the slow clear/home commands
//   init_rom()     - power-on command sequence (LCD_INIT_EN builds only)
// Configuration macro: LCD_INIT_EN.
package lcd_pkg;

    localparam int LCD_TMR_W    = 20;
    localparam int LCD_INIT_LEN = 4;

    localparam logic [7:0] LCD_CMD_CLEAR  = 8'h01;
    localparam logic [7:0] LCD_CMD_HOME   = 8'h02;
    localparam logic [7:0] LCD_CMD_FUNC8  = 8'h38;
    localparam logic [7:0] LCD_CMD_DISPON = 8'h0C;
    localparam logic [7:0] LCD_CMD_ENTRY  = 8'h06;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        WAIT
`ifdef LCD_INIT_EN
        ,
        PWRUP,
        INIT
`endif
    } lcd_state_t;

    // A state lasting N cycles loads N-1 and leaves when the counter is 0.
    function automatic logic [LCD_TMR_W-1:0] cyc_load(input int n);
        return LCD_TMR_W'(n - 1);
    endfunction

    // 0x03 is decoded as "home" by the HD44780 (bit 0 is don't-care), so it
    // needs the long execution time as well.
    function automatic logic is_clear_cmd(input logic rs, input logic [7:0] data);
        return !rs && (data == LCD_CMD_CLEAR || data == LCD_CMD_HOME || data == 8'h03);
    endfunction

`ifdef LCD_INIT_EN
    function automatic logic [7:0] init_rom(input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = LCD_CMD_FUNC8;
            2'd1:    b = LCD_CMD_DISPON;
            2'd2:    b = LCD_CMD_ENTRY;
            default: b = LCD_CMD_CLEAR;
        endcase
        return b;
    endfunction
`endif

endpackage

// File: rtl/lcd_timer.sv
// lcd_timer: load/decrement down-counter shared by every timed FSM state.
//   i_clk      - clock
//   i_reset    - synchronous active-high reset (count -> 0)
//   i_load     - load i_load_val this edge (has priority over decrement)
//   i_load_val - value to load (cycle count minus one)
//   o_done     - count is zero; the counter holds at zero and never wraps
// Configuration macro: none (LCD_INIT_EN does not affect this file).
module lcd_timer #(
    parameter int W = 20
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_done
);

    logic [W-1:0] count;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            count <= '0;
        end else if (i_load) begin
            count <= i_load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign o_done = (count == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// lcd_ctrl: HD44780-style character LCD write controller.
// Takes one byte per write from the LSU LCD register and sequences the LCD
// bus: RS/DB setup, EN pulse, hold, then the controller execution wait.
//
// Handshake: a write transfers on a rising edge where i_valid && o_ready.
// o_ready is high only in IDLE and is decoded straight from the state
// register. i_valid while o_ready is low is dropped, never queued; software
// polls o_busy (= ~o_ready) before writing.
//
// Ports:
//   i_clk, i_reset          - clock, synchronous active-high reset
//   i_valid, i_rs, i_data   - write strobe, register select, byte
//   i_on                    - display power enable
//   o_ready, o_busy         - write can be accepted / its inverse
//   o_lcd_data, o_lcd_rs    - LCD DB[7:0] and RS, latched at acceptance
//   o_lcd_rw                - LCD RW, tied low (write-only bus)
//   o_lcd_en                - LCD E, registered
//   o_lcd_on                - i_on delayed by one cycle
//   o_dbg_state             - current FSM state, for observation
// Configuration macro: LCD_INIT_EN adds a power-up delay and a ROM-driven
// init sequence (0x38, 0x0C, 0x06, 0x01) before the first software write.
module lcd_ctrl
    import lcd_pkg::*;
#(
    parameter int SETUP_CYC   = 2,
    parameter int PULSE_CYC   = 12,
    parameter int HOLD_CYC    = 2,
    parameter int EXEC_CYC    = 2000,
    parameter int CLEAR_CYC   = 80000,
    parameter int POWERUP_CYC = 800000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_valid,
    input  logic       i_rs,
    input  logic [7:0] i_data,
    input  logic       i_on,
    output logic       o_ready,
    output logic       o_busy,
    output logic [7:0] o_lcd_data,
    output logic       o_lcd_rs,
    output logic       o_lcd_rw,
    output logic       o_lcd_en,
    output logic       o_lcd_on,
    output lcd_state_t o_dbg_state
);

    localparam int MAX_CYC = 1 << LCD_TMR_W;

    if (SETUP_CYC < 1 || PULSE_CYC < 1 || HOLD_CYC < 1 || EXEC_CYC < 1 ||
        CLEAR_CYC < 1 || POWERUP_CYC < 1 || CLEAR_CYC > MAX_CYC ||
        EXEC_CYC > MAX_CYC || POWERUP_CYC > MAX_CYC) begin : g_bad_params
        $error("lcd_ctrl: timing parameters must lie in 1..2**20");
    end

    lcd_state_t           state;
    lcd_state_t           state_next;
    logic                 tmr_load;
    logic [LCD_TMR_W-1:0] tmr_val;
    logic                 tmr_done;
    logic                 accept;

`ifdef LCD_INIT_EN
    logic [2:0] init_idx;     // number of ROM bytes already issued
    logic       pwrup_armed;  // power-up delay has been loaded into the timer
`endif

    assign accept = (state == IDLE) && i_valid;

    lcd_timer #(
        .W(LCD_TMR_W)
    ) u_timer (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_load    (tmr_load),
        .i_load_val(tmr_val),
        .o_done    (tmr_done)
    );

    always_comb begin
        state_next = state;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        case (state)
            IDLE: begin
                if (i_valid) begin
                    state_next = SETUP;
                    tmr_load   = 1'b1;
                    tmr_val    = cyc_load(SETUP_CYC);
                end
            end
            SETUP: begin
                if (tmr_done) begin
                    state_next = PULSE;
                    tmr_load   = 1'b1;
                    tmr_val    = cyc_load(PULSE_CYC);
                end
            end
            PULSE: begin
                if (tmr_done) begin
                    state_next = HOLD;
                    tmr_load   = 1'b1;
                    tmr_val    = cyc_load(HOLD_CYC);
                end
            end
            HOLD: begin
                if (tmr_done) begin
                    state_next = WAIT;
                    tmr_load   = 1'b1;
                    // Decided from the latched byte, which is stable by now.
                    tmr_val    = is_clear_cmd(o_lcd_rs, o_lcd_data) ?
                                 cyc_load(CLEAR_CYC) : cyc_load(EXEC_CYC);
                end
            end
            WAIT: begin
                if (tmr_done) begin
`ifdef LCD_INIT_EN
                    state_next = (init_idx == 3'(LCD_INIT_LEN)) ? IDLE : INIT;
`else
                    state_next = IDLE;
`endif
                end
            end
`ifdef LCD_INIT_EN
            PWRUP: begin
                // The counter comes out of reset at zero, so the first
                // PWRUP cycle loads the delay and later cycles watch it.
                if (!pwrup_armed) begin
                    tmr_load = 1'b1;
                    tmr_val  = cyc_load(POWERUP_CYC);
                end else if (tmr_done) begin
                    state_next = INIT;
                end
            end
            INIT: begin
                state_next = SETUP;
                tmr_load   = 1'b1;
                tmr_val    = cyc_load(SETUP_CYC);
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
`ifdef LCD_INIT_EN
            state       <= PWRUP;
            init_idx    <= '0;
            pwrup_armed <= 1'b0;
`else
            state       <= IDLE;
`endif
            o_lcd_en    <= 1'b0;
            o_lcd_rs    <= 1'b0;
            o_lcd_data  <= 8'h00;
            o_lcd_on    <= 1'b0;
        end else begin
            state    <= state_next;
            // EN is a flop driven from the next state, so it is aligned with
            // PULSE and cannot glitch.
            o_lcd_en <= (state_next == PULSE);
            o_lcd_on <= i_on;
            if (accept) begin
                o_lcd_rs   <= i_rs;
                o_lcd_data <= i_data;
            end
`ifdef LCD_INIT_EN
            else if (state == INIT) begin
                o_lcd_rs   <= 1'b0;
                o_lcd_data <= init_rom(init_idx[1:0]);
                init_idx   <= init_idx + 3'd1;
            end
            if (state == PWRUP) begin
                pwrup_armed <= 1'b1;
            end
`endif
        end
    end

    assign o_ready     = (state == IDLE);
    assign o_busy      = ~o_ready;
    assign o_lcd_rw    = 1'b0;
    assign o_dbg_state = state;

endmodule

// File: tb/tb_lcd_ctrl.sv
// tb_lcd_ctrl: self-checking bench for lcd_ctrl with short timing parameters.
// Cycle numbering: the acceptance edge closes cycle 0; outputs are sampled on
// the falling edge inside each following cycle.
module tb_lcd_ctrl;

    localparam int S  = 1;
    localparam int P  = 3;
    localparam int H  = 1;
    localparam int E  = 5;
    localparam int C  = 20;
    localparam int PU = 10;

    logic       i_clk   = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_valid = 1'b0;
    logic       i_rs    = 1'b0;
    logic [7:0] i_data  = 8'h00;
    logic       i_on    = 1'b0;
    logic       o_ready;
    logic       o_busy;
    logic [7:0] o_lcd_data;
    logic       o_lcd_rs;
    logic       o_lcd_rw;
    logic       o_lcd_en;
    logic       o_lcd_on;
    logic [2:0] dbg_state;

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 i_clk = ~i_clk;

    lcd_ctrl #(
        .SETUP_CYC  (S),
        .PULSE_CYC  (P),
        .HOLD_CYC   (H),
        .EXEC_CYC   (E),
        .CLEAR_CYC  (C),
        .POWERUP_CYC(PU)
    ) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_valid    (i_valid),
        .i_rs       (i_rs),
        .i_data     (i_data),
        .i_on       (i_on),
        .o_ready    (o_ready),
        .o_busy     (o_busy),
        .o_lcd_data (o_lcd_data),
        .o_lcd_rs   (o_lcd_rs),
        .o_lcd_rw   (o_lcd_rw),
        .o_lcd_en   (o_lcd_en),
        .o_lcd_on   (o_lcd_on),
        .o_dbg_state(dbg_state)
    );

    // ---------------- reference model ----------------
    // Execution wait chosen by the rule: command 0x01..0x03 is slow.
    function automatic int wait_len(input logic rs, input logic [7:0] d);
        if (!rs && d >= 8'h01 && d <= 8'h03) return C;
        return E;
    endfunction

    // Cycle at which o_ready returns after acceptance at cycle 0.
    function automatic int latency(input logic rs, input logic [7:0] d);
        return S + P + H + wait_len(rs, d) + 1;
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        i_reset = 1'b1;
        i_on    = 1'b1;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        checks++;
        if (o_lcd_en !== 1'b0 || o_lcd_rs !== 1'b0 || o_lcd_data !== 8'h00 ||
            o_lcd_on !== 1'b0 || o_lcd_rw !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got en=%b rs=%b data=%h on=%b rw=%b exp all 0",
                     o_lcd_en, o_lcd_rs, o_lcd_data, o_lcd_on, o_lcd_rw);
        end
        i_reset = 1'b0;
        @(negedge i_clk);
        checks++;
        if (o_ready !== 1'b1 || o_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready got ready=%b busy=%b exp 1/0", o_ready, o_busy);
        end
        checks++;
        if (o_lcd_on !== 1'b1) begin
            failures++;
            $display("FAIL reset_on_follow got %b exp 1", o_lcd_on);
        end
    endtask

    // One complete write checked cycle by cycle. An extra i_valid with
    // drop_data is raised during cycle drop_cycle (0 = none) and must be lost.
    task automatic test_write(input logic rs, input logic [7:0] d,
                              input int drop_cycle, input logic [7:0] drop_data);
        int   lat;
        int   pulses;
        logic prev_en;
        logic prev_on;
        logic exp_en;
        logic exp_rdy;
        lat = latency(rs, d);
        @(negedge i_clk);
        checks++;
        if (o_ready !== 1'b1) begin
            failures++;
            $display("FAIL wr_pre_ready got %b exp 1", o_ready);
        end
        i_valid = 1'b1;
        i_rs    = rs;
        i_data  = d;
        @(posedge i_clk);
        pulses  = 0;
        prev_en = 1'b0;
        prev_on = i_on;
        for (int c = 1; c <= lat; c++) begin
            @(negedge i_clk);
            exp_en  = (c >= S + 1) && (c <= S + P);
            exp_rdy = (c == lat);
            checks++;
            if (o_lcd_en !== exp_en) begin
                failures++;
                $display("FAIL wr_en cyc=%0d got %b exp %b", c, o_lcd_en, exp_en);
            end
            checks++;
            if (o_ready !== exp_rdy || o_busy !== ~exp_rdy) begin
                failures++;
                $display("FAIL wr_ready cyc=%0d got ready=%b busy=%b exp ready=%b",
                         c, o_ready, o_busy, exp_rdy);
            end
            checks++;
            if (o_lcd_data !== d || o_lcd_rs !== rs || o_lcd_rw !== 1'b0) begin
                failures++;
                $display("FAIL wr_bus cyc=%0d got data=%h rs=%b rw=%b exp data=%h rs=%b rw=0",
                         c, o_lcd_data, o_lcd_rs, o_lcd_rw, d, rs);
            end
            checks++;
            if (o_lcd_on !== prev_on) begin
                failures++;
                $display("FAIL wr_on cyc=%0d got %b exp %b", c, o_lcd_on, prev_on);
            end
            if (o_lcd_en && !prev_en) pulses++;
            prev_en = o_lcd_en;
            i_on    = 1'($urandom_range(0, 1));
            prev_on = i_on;
            i_valid = (c == drop_cycle);
            if (c == drop_cycle) begin
                i_rs   = ~rs;
                i_data = drop_data;
            end
        end
        i_valid = 1'b0;
        checks++;
        if (pulses != 1) begin
            failures++;
            $display("FAIL wr_pulses got %0d exp 1", pulses);
        end
    endtask

    task automatic test_on();
        logic prev_on;
        @(negedge i_clk);
        prev_on = i_on;
        for (int k = 0; k < 10; k++) begin
            @(negedge i_clk);
            checks++;
            if (o_lcd_on !== prev_on || o_ready !== 1'b1 || o_lcd_en !== 1'b0) begin
                failures++;
                $display("FAIL on_toggle k=%0d got on=%b ready=%b en=%b exp on=%b ready=1 en=0",
                         k, o_lcd_on, o_ready, o_lcd_en, prev_on);
            end
            i_on    = ~i_on;
            prev_on = i_on;
        end
    endtask

    task automatic test_back_to_back();
        int lat1;
        int lat2;
        lat1 = latency(1'b1, 8'h33);
        lat2 = latency(1'b0, 8'h80);
        @(negedge i_clk);
        i_valid = 1'b1;
        i_rs    = 1'b1;
        i_data  = 8'h33;
        @(posedge i_clk);
        for (int c = 1; c <= lat1; c++) begin
            @(negedge i_clk);
            if (c == 1) begin
                i_rs   = 1'b0;
                i_data = 8'h80;
            end
            checks++;
            if (o_ready !== (c == lat1) || o_lcd_data !== 8'h33) begin
                failures++;
                $display("FAIL b2b_first cyc=%0d got ready=%b data=%h exp ready=%b data=33",
                         c, o_ready, o_lcd_data, (c == lat1));
            end
        end
        for (int c = 1; c <= lat2; c++) begin
            @(negedge i_clk);
            i_valid = 1'b0;
            checks++;
            if (o_ready !== (c == lat2) || o_lcd_data !== 8'h80 || o_lcd_rs !== 1'b0 ||
                o_lcd_en !== ((c >= S + 1) && (c <= S + P))) begin
                failures++;
                $display("FAIL b2b_second cyc=%0d got ready=%b data=%h rs=%b en=%b",
                         c, o_ready, o_lcd_data, o_lcd_rs, o_lcd_en);
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge i_clk);
        i_on    = 1'b1;
        i_valid = 1'b1;
        i_rs    = 1'b1;
        i_data  = 8'h5A;
        @(posedge i_clk);
        @(negedge i_clk);
        i_valid = 1'b0;
        repeat (2) @(negedge i_clk);
        checks++;
        if (o_lcd_en !== 1'b1) begin
            failures++;
            $display("FAIL mid_pre_en got %b exp 1", o_lcd_en);
        end
        i_reset = 1'b1;
        @(negedge i_clk);
        checks++;
        if (o_lcd_en !== 1'b0 || o_lcd_rs !== 1'b0 || o_lcd_data !== 8'h00 || o_lcd_on !== 1'b0) begin
            failures++;
            $display("FAIL mid_abort got en=%b rs=%b data=%h on=%b exp all 0",
                     o_lcd_en, o_lcd_rs, o_lcd_data, o_lcd_on);
        end
        i_reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge i_clk);
            checks++;
            if (o_ready !== 1'b1 || o_lcd_en !== 1'b0) begin
                failures++;
                $display("FAIL mid_no_resume k=%0d got ready=%b en=%b exp 1/0", k, o_ready, o_lcd_en);
            end
        end
    endtask

    task automatic test_random();
        logic       rs;
        logic [7:0] d;
        int         drop;
        for (int n = 0; n < 8; n++) begin
            rs = 1'($urandom_range(0, 1));
            d  = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom_range(0, 255));
            drop = $urandom_range(0, latency(rs, d) - 1);
            test_write(rs, d, drop, 8'($urandom_range(0, 255)));
        end
    endtask

`ifdef LCD_INIT_EN
    task automatic test_init();
        logic prev_en;
        int   first_rise;
        int   last_fall;
        int   cyc;
        logic done;
        exp_q = {8'h38, 8'h0C, 8'h06, 8'h01};
        i_reset = 1'b1;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_reset    = 1'b0;
        prev_en    = 1'b0;
        first_rise = -1;
        last_fall  = -1;
        done       = 1'b0;
        cyc        = 0;
        while (!done && cyc < 2000) begin
            @(negedge i_clk);
            cyc++;
            if (cyc == 1) begin
                checks++;
                if (o_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL init_not_ready got %b exp 0", o_ready);
                end
            end
            if (o_lcd_en && !prev_en) begin
                if (first_rise < 0) first_rise = cyc;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL init_extra_pulse got data=%h exp none", o_lcd_data);
                end else begin
                    if (o_lcd_data !== exp_q[0] || o_lcd_rs !== 1'b0) begin
                        failures++;
                        $display("FAIL init_byte got data=%h rs=%b exp data=%h rs=0",
                                 o_lcd_data, o_lcd_rs, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
            end
            if (!o_lcd_en && prev_en) last_fall = cyc;
            prev_en = o_lcd_en;
            if (o_ready === 1'b1) begin
                done    = 1'b1;
                i_valid = 1'b0;
            end else begin
                i_valid = 1'($urandom_range(0, 1));
                i_rs    = 1'b1;
                i_data  = 8'hAA;
            end
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL init_timeout got ready=%b after %0d cycles exp 1", o_ready, cyc);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL init_missing got %0d bytes left exp 0", exp_q.size());
        end
        checks++;
        if (first_rise <= PU) begin
            failures++;
            $display("FAIL init_powerup got first EN at %0d exp > %0d", first_rise, PU);
        end
        checks++;
        if (cyc - last_fall != H + C) begin
            failures++;
            $display("FAIL init_clear_wait got %0d exp %0d", cyc - last_fall, H + C);
        end
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
`ifdef LCD_INIT_EN
        test_init();
        test_write(1'b1, 8'h41, 5, 8'h42);
        test_write(1'b0, 8'h01, 0, 8'h00);
        test_random();
`else
        test_reset();
        test_write(1'b1, 8'h41, 0, 8'h00);
        test_write(1'b0, 8'h01, 0, 8'h00);
        test_write(1'b1, 8'h01, 0, 8'h00);
        test_write(1'b1, 8'h41, 5, 8'h42);
        test_write(1'b0, 8'h03, 0, 8'h00);
        test_write(1'b0, 8'h04, 0, 8'h00);
        test_on();
        test_back_to_back();
        test_reset_mid();
        test_random();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
